// File: rtl/sim_link_pkg.sv
// Shared definitions for the simulator UART link: bit timing, detector bit
// positions and receiver FSM state encoding.
package sim_link_pkg;

    localparam int unsigned FRONT_BIT = 0;
    localparam int unsigned LEFT_BIT  = 1;
    localparam int unsigned RIGHT_BIT = 2;
    localparam int unsigned BACK_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver core: rx synchroniser, framing FSM and shift register.
// data holds the last correctly framed byte; valid/frame_err are one-cycle strobes.
module uart_rx_core
    import sim_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state, next_state;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_clr, shift_en, load_good, load_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (rx_prev && !rx_s) next_state = ST_START;
            ST_START: if (clk_cnt == CNT_HALF) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (clk_cnt == CNT_FULL && bit_idx == 3'd7) next_state = ST_STOP;
            ST_STOP:  if (clk_cnt == CNT_FULL) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_good = 1'b0;
        load_bad  = 1'b0;
        case (state)
            ST_IDLE:  cnt_clr = 1'b1;
            ST_START: cnt_clr = (clk_cnt == CNT_HALF);
            ST_DATA: begin
                cnt_clr  = (clk_cnt == CNT_FULL);
                shift_en = (clk_cnt == CNT_FULL);
            end
            ST_STOP: begin
                cnt_clr   = (clk_cnt == CNT_FULL);
                load_good = (clk_cnt == CNT_FULL) && rx_s;
                load_bad  = (clk_cnt == CNT_FULL) && !rx_s;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Synchroniser and edge-detect history reset to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            clk_cnt   <= cnt_clr ? '0 : clk_cnt + 1'b1;
            valid     <= load_good;
            frame_err <= load_bad;
            if (state != ST_DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[7:1]};
            end
            if (load_good) begin
                data <= shift;
            end
        end
    end

endmodule

// File: rtl/sim_status_receiver.sv
// Status-byte receiver from the car simulator: decoded obstacle flags and a
// link watchdog on top of the UART receive core.
module sim_status_receiver
    import sim_link_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned BAUD           = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rec_byte,
    output logic       rec_valid,
    output logic       frame_err,
    output logic       front_blocked,
    output logic       left_blocked,
    output logic       right_blocked,
    output logic       back_blocked,
    output logic       link_ok,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] link_timer;
    logic             seen_good;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (rec_byte),
        .valid    (rec_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // rec_byte is itself the held register of the last good byte, so the flags
    // are taken from it and change in the same cycle as rec_valid.
    assign front_blocked = rec_byte[FRONT_BIT];
    assign left_blocked  = rec_byte[LEFT_BIT];
    assign right_blocked = rec_byte[RIGHT_BIT];
    assign back_blocked  = rec_byte[BACK_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_timer <= '0;
            seen_good  <= 1'b0;
        end else if (rec_valid) begin
            link_timer <= '0;
            seen_good  <= 1'b1;
        end else if (link_timer != TMR_MAX) begin
            link_timer <= link_timer + 1'b1;
        end
    end

    assign link_ok = seen_good && (link_timer < TMR_MAX);

endmodule

// File: tb/tb_sim_status_receiver.sv
// Scoreboard bench for sim_status_receiver at 10 clk/bit with a 500-cycle link timeout.
module tb_sim_status_receiver;

    localparam int unsigned BIT = 10;
    localparam int TMO = 500;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rec_byte;
    logic       rec_valid, frame_err;
    logic       front_blocked, left_blocked, right_blocked, back_blocked;
    logic       link_ok, busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit         err;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    int         vcyc[$];
    logic [7:0] last_good = '0;
    int         cyc = 0;
    int         last_valid = -1;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       exp_link;
    exp_t       e;

    sim_status_receiver #(
        .CLK_FREQ_HZ   (1_000_000),
        .BAUD          (100_000),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rec_byte     (rec_byte),
        .rec_valid    (rec_valid),
        .frame_err    (frame_err),
        .front_blocked(front_blocked),
        .left_blocked (left_blocked),
        .right_blocked(right_blocked),
        .back_blocked (back_blocked),
        .link_ok      (link_ok),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: link_ok expected high for cycles 1..TMO after the last good-byte strobe
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_valid = -1;
            last_good  = '0;
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end else begin
            exp_link = (last_valid >= 0) && (cyc - last_valid >= 1) && (cyc - last_valid <= TMO);
            chk("link_ok", {31'b0, link_ok}, {31'b0, exp_link});
            chk("strobe_excl", {31'b0, rec_valid && frame_err}, 32'd0);
            if (rec_valid || frame_err) begin
                chk("strobe_width", {31'b0, (rec_valid && prev_valid) || (frame_err && prev_ferr)}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind_err", {31'b0, frame_err}, {31'b0, e.err});
                    if (!e.err) last_good = e.b;
                end
            end
            if (rec_valid) begin
                vcyc.push_back(cyc);
                last_valid = cyc;
            end
            chk("rec_byte", {24'b0, rec_byte}, {24'b0, last_good});
            chk("flags", {28'b0, back_blocked, right_blocked, left_blocked, front_blocked},
                {28'b0, last_good[3:0]});
            prev_valid = rec_valid;
            prev_ferr  = frame_err;
        end
    end

    task automatic drive(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t x;
        x.err = !stop;
        x.b   = b;
        sb.push_back(x);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(stop, BIT);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {22'b0, rec_byte, rec_valid, frame_err, front_blocked, left_blocked,
                   right_blocked, back_blocked, link_ok, busy}, 32'd0);
    endtask

    initial begin
        int n0;
        logic [7:0] rb;
        bit err;
        int unsigned gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        drive(1'b1, 5);

        send_frame(8'h05, 1'b1);
        drive(1'b1, 20);
        chk("first_count", vcyc.size(), 32'd1);
        chk("first_byte", {24'b0, rec_byte}, 32'h05);
        chk("first_flags", {28'b0, back_blocked, right_blocked, left_blocked, front_blocked}, 32'b0101);
        chk("first_link", {31'b0, link_ok}, 32'd1);

        drive(1'b0, 3);
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("glitch_busy_idle", {31'b0, busy}, 32'd0);
        drive(1'b1, 20);
        chk("glitch_no_strobe", vcyc.size(), 32'd1);

        send_frame(8'hFF, 1'b0);
        drive(1'b1, 20);
        chk("ferr_keeps_byte", {24'b0, rec_byte}, 32'h05);

        n0 = vcyc.size();
        send_frame(8'h08, 1'b1);
        send_frame(8'h02, 1'b1);
        drive(1'b1, 20);
        chk("b2b_count", vcyc.size() - n0, 32'd2);
        if (vcyc.size() - n0 == 2) chk("b2b_spacing", vcyc[n0+1] - vcyc[n0], 32'd100);
        chk("b2b_flags", {28'b0, back_blocked, left_blocked}, 32'b01);

        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(i[0], BIT);
        drive(1'b1, 5);
        rst = 1'b1;
        drive(1'b1, 3);
        chk_all_zero("midframe_reset");
        rst = 1'b0;
        drive(1'b1, 120);
        chk("reset_no_strobe", sb.size(), 32'd0);
        send_frame(8'h0A, 1'b1);
        drive(1'b1, 20);
        chk("after_reset_byte", {24'b0, rec_byte}, 32'h0A);

        drive(1'b1, 500);
        chk("timeout_link", {31'b0, link_ok}, 32'd0);
        send_frame(8'h03, 1'b1);
        drive(1'b1, 5);
        chk("link_restored", {31'b0, link_ok}, 32'd1);

        for (int k = 0; k < 40; k++) begin
            rb  = 8'($urandom);
            err = ($urandom_range(0, 5) == 0);
            send_frame(rb, !err);
            gap = err ? $urandom_range(3, 20) : $urandom_range(0, 20);
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(480, 560);
            drive(1'b1, gap);
        end

        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 32'd0);
        drive(1'b1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
